ub_arbiter: RTL
===============

UB_ARBITER -- requirements
Module: ub_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESS_SIZE, default 10, the unified buffer address width.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of ACCESS cycles before abort; it is used only under UB_ARB_TIMEOUT_EN.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port req, input, 3, per-requester access request; bit 0 = rx FIFO path, bit 1 = compute path, bit 2 = tx FIFO path.
REQ-006 The block SHALL have port req_we, input, 3, per-requester direction: 1 = write, 0 = read.
REQ-007 The block SHALL have port req_addr, input, 3*ADDRESS_SIZE, packed per-requester address; requester i occupies bits [i*ADDRESS_SIZE +: ADDRESS_SIZE].
REQ-008 The block SHALL have port gnt, output, 3, one-hot current owner; all zero when there is no owner.
REQ-009 The block SHALL have port ack, output, 3, one-cycle completion pulse to the owner.
REQ-010 The block SHALL have port buf_we, output, 1, buffer write strobe.
REQ-011 The block SHALL have port buf_re, output, 1, buffer read strobe.
REQ-012 The block SHALL have port buf_address, output, ADDRESS_SIZE, buffer address.
REQ-013 The block SHALL have port buf_fifo_en, output, 1, buffer FIFO-side select; high when the owner is 0 or 2.
REQ-014 The block SHALL have port buf_compute_en, output, 1, buffer compute-side select; high when the owner is 1.
REQ-015 The block SHALL have port buf_done, input, 1, buffer access complete.
REQ-016 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 The block SHALL have port err, output, 1, timeout pulse.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS and RELEASE; all outputs SHALL be registered.
REQ-019 In IDLE with any req bit high, the block SHALL select a winner by round-robin, searching from (last_winner+1) mod 3 upward with wrap-around.
REQ-020 On the selecting edge, the block SHALL register the winner, its req_we and its req_addr, update last_winner to the winner, and go to ACCESS.
REQ-021 In the cycle after a req seen in IDLE, gnt, buf_address, buf_fifo_en/buf_compute_en and exactly one of buf_we/buf_re SHALL be valid, giving a latency of 1 cycle.
REQ-022 In ACCESS, all strobes and the latched address SHALL be held constant until buf_done is sampled high.
REQ-023 When buf_done is sampled high in ACCESS, the block SHALL go to RELEASE: strobes 0, gnt 0, ack[owner] 1 for that single cycle.
REQ-024 RELEASE SHALL always go to IDLE, so the minimum spacing between grants is 3 cycles.
REQ-025 Deassertion of req during ACCESS SHALL NOT abort the access; it completes and ack is still pulsed.
REQ-026 The block SHALL ignore buf_done outside ACCESS.
REQ-027 The block SHALL ignore req_we and req_addr changes after latching.
REQ-028 Requesters SHALL hold req until ack; a req still high in IDLE after its ack SHALL be treated as a new request.
REQ-029 With all three requesting continuously, grants SHALL rotate 0,1,2,0,...; no requester SHALL wait more than 2 other grants.
REQ-030 The block SHALL never assert buf_we and buf_re together.
REQ-031 The block SHALL never assert more than one gnt bit.

Reset
REQ-032 When rst is low, the block SHALL asynchronously force: state IDLE, gnt 0, ack 0, buf_we 0, buf_re 0, buf_address 0, buf_fifo_en 0, buf_compute_en 0, busy 0, err 0, last_winner 2 (so requester 0 wins first), timeout counter 0.
REQ-033 Reset mid-ACCESS SHALL abort the access with no ack; the block SHALL resume from IDLE on the first clk edge after rst rises.

Configuration
REQ-034 With macro UB_ARB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if it reaches TIMEOUT_CYCLES without buf_done, the block SHALL go to RELEASE with ack[owner] and err both pulsed for 1 cycle.
REQ-035 With UB_ARB_TIMEOUT_EN not defined, ACCESS SHALL wait indefinitely, err SHALL be constant 0, and no counter SHALL be instantiated.

Verification
REQ-036 rst low, then release, with req=3'b010, req_we[1]=1, addr1=0x155 -> next cycle gnt=010, buf_we=1, buf_compute_en=1, buf_address=0x155; buf_done after 4 cycles -> ack=010 for 1 cycle.
REQ-037 req=3'b111 held high, buf_done 1 cycle after each strobe -> gnt order 001, 010, 100, 001, with 3-cycle spacing.
REQ-038 req0 read at addr 0x3FF, req dropped in ACCESS -> buf_re held until buf_done, then ack[0] pulses.
REQ-039 rst asserted in ACCESS -> all outputs 0 immediately, without waiting for a clk edge, and no ack; after release, req2 -> gnt=100.
REQ-040 UB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, buf_done never asserted -> after 8 ACCESS cycles, err=1 and ack=owner for 1 cycle, then IDLE; without the macro, busy stays 1.

Source files
------------

// File: rtl/ub_arbiter.sv
// Three-requester round-robin arbiter for the unified buffer (rx FIFO, compute, tx FIFO).
// Optional ACCESS timeout abort is enabled with macro UB_ARB_TIMEOUT_EN.
module ub_arbiter #(
  parameter int ADDRESS_SIZE   = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                req,
  input  logic [2:0]                req_we,
  input  logic [3*ADDRESS_SIZE-1:0] req_addr,
  output logic [2:0]                gnt,
  output logic [2:0]                ack,
  output logic                      buf_we,
  output logic                      buf_re,
  output logic [ADDRESS_SIZE-1:0]   buf_address,
  output logic                      buf_fifo_en,
  output logic                      buf_compute_en,
  input  logic                      buf_done,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                last_q, last_d;
  logic [2:0]                gnt_q, gnt_d;
  logic [2:0]                ack_q, ack_d;
  logic                      we_q, we_d;
  logic                      re_q, re_d;
  logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
  logic                      fifo_q, fifo_d;
  logic                      comp_q, comp_d;
  logic                      busy_q, busy_d;
  logic [1:0]                winner;
  logic                      timeout;

`ifdef UB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Counter is zero on entry to ACCESS and advances once per ACCESS cycle.
  assign timeout = (state_q == ACCESS) && (tmo_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    err_d = 1'b0;
    if (state_q == ACCESS) begin
      tmo_d = tmo_q + 1'b1;
      err_d = timeout && !buf_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Round-robin search starting just after the previous winner.
  always_comb begin
    unique case (last_q)
      2'd0:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ack_d   = 3'b000;
    we_d    = we_q;
    re_d    = re_q;
    addr_d  = addr_q;
    fifo_d  = fifo_q;
    comp_d  = comp_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
          last_d  = winner;
          gnt_d   = 3'b001 << winner;
          we_d    = req_we[winner];
          re_d    = !req_we[winner];
          addr_d  = req_addr[winner*ADDRESS_SIZE +: ADDRESS_SIZE];
          fifo_d  = (winner != 2'd1);
          comp_d  = (winner == 2'd1);
        end
      end
      ACCESS: begin
        if (buf_done || timeout) begin
          state_d = RELEASE;
          gnt_d   = 3'b000;
          ack_d   = gnt_q;
          we_d    = 1'b0;
          re_d    = 1'b0;
          fifo_d  = 1'b0;
          comp_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      gnt_q   <= 3'b000;
      ack_q   <= 3'b000;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      fifo_q  <= 1'b0;
      comp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      fifo_q  <= fifo_d;
      comp_q  <= comp_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt            = gnt_q;
  assign ack            = ack_q;
  assign buf_we         = we_q;
  assign buf_re         = re_q;
  assign buf_address    = addr_q;
  assign buf_fifo_en    = fifo_q;
  assign buf_compute_en = comp_q;
  assign busy           = busy_q;

endmodule
